chronos_dmem_responder: RTL
===========================

Name: chronos_dmem_responder

Overview:
- Data-memory responder; the far end of the core's dmem request interface.
- Accepts one load/store request at a time, performs a byte/half/word access into a local word-organised SRAM, and returns a response after a programmable number of cycles.
- Adds ready/valid flow control and an error flag, so the core can be tested against multi-cycle memory latency.

Parameters:
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from request accept to response; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dmem_req_val  in  1  request valid.
- dmem_req_rdy  out  1  responder can accept a request this cycle.
- dmem_req_rw  in  1  1 = store, 0 = load.
- dmem_req_addr  in  32  byte address.
- dmem_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dmem_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- dmem_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- dmem_resp_val  out  1  one-cycle response pulse.
- dmem_resp_data  out  32  load data, right-aligned and extended; 0 for stores and errors.
- dmem_resp_err  out  1  access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; the wait counter clears.
  - dmem_resp_val=0, dmem_resp_data=0, dmem_resp_err=0, dmem_req_rdy=1.
  - SRAM contents are not reset.
  - Reset asserted mid-transaction abandons that transaction with no response; a store already committed stays committed.
- Handshake:
  - A request is accepted at a rising edge when dmem_req_val=1 and dmem_req_rdy=1.
  - Request fields are sampled only at accept; they are don't-care at other times.
- FSM: IDLE and WAIT.
  - IDLE, on accept: go to WAIT with cnt=LATENCY-1.
  - WAIT, cnt!=0: decrement cnt.
  - WAIT, cnt==0: raise dmem_resp_val, dmem_resp_data and dmem_resp_err for exactly that cycle (registered outputs).
  - Leaving the cnt==0 cycle: return to IDLE, or, if a new request is accepted in that same cycle, reload cnt=LATENCY-1 and stay in WAIT.
- dmem_req_rdy = (state==IDLE) || (state==WAIT && cnt==0). This sustains one request every LATENCY cycles.
- Latency: a request accepted at edge E yields dmem_resp_val high in the cycle following edge E+LATENCY-1 (LATENCY=1 gives a response in the cycle after accept).
- Error checks, evaluated at accept:
  - size 3 → err.
  - size 1 with addr[0]!=0 → err.
  - size 2 with addr[1:0]!=0 → err.
  - addr[31:ADDR_WIDTH+2] nonzero → err.
  - On error: no SRAM write, response data 0, err=1.
- Stores: the SRAM is updated at the accept edge.
  - Byte lanes come from size and addr[1:0]; wdata is replicated onto the selected lane(s).
  - Response data is 0.
- Loads:
  - The word is read at accept using the current SRAM contents, so a load accepted after a store sees the new data.
  - The selected byte/half is shifted down and extended per dmem_req_unsigned, then held in the response register until the response cycle.
- The response register keeps its last value when dmem_resp_val=0; the bench checks data only when val=1.

Decomposition:
- defines.vh gains:
  - MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W size codes.
  - DMEM_ST_IDLE and DMEM_ST_WAIT state encodings.
  - MEM_RW_LOAD and MEM_RW_STORE.
- Sub-module chronos_dmem_sram: 2^ADDR_WIDTH x 32 array with 4-bit byte-write-enable and a combinational read port.
- The lane/extension logic and FSM stay in chronos_dmem_responder.

Test Plan:
- Word store then load, LATENCY=1: store 0xDEADBEEF to 0x10, then load word 0x10 → two resp_val pulses, one cycle after each accept; load data 0xDEADBEEF; err=0.
- Byte and half extension: after the above, load byte 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE; half 0x12 signed → 0xFFFFDEAD.
- Byte store merge: store byte 0x55 to 0x11, then load word 0x10 → 0xDEAD55EF.
- Errors:
  - Load half 0x11 → err=1, data 0.
  - Store word 0x12 → err=1 and memory unchanged (a later load of 0x10 still returns the prior value).
  - Address 0x00001000 with ADDR_WIDTH=10 → err=1.
- Latency and back-to-back, LATENCY=3:
  - Hold val=1 continuously → accepts every 3 cycles.
  - rdy low for 2 of every 3 cycles.
  - resp_val high on exactly the accept-again cycles.
- Reset mid-op, LATENCY=4:
  - Assert rst=0 two cycles after accept → outputs go to 0 and rdy=1 immediately (asynchronously); no response appears.
  - A following load returns the correct data.

Source files
------------

// File: rtl/chronos_dmem_responder_pkg.sv
// chronos_dmem_responder_pkg: size/rw/state encodings and lane helpers for the dmem responder.
package chronos_dmem_responder_pkg;
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic MEM_RW_LOAD  = 1'b0;
  localparam logic MEM_RW_STORE = 1'b1;
  typedef enum logic {DMEM_ST_IDLE = 1'b0, DMEM_ST_WAIT = 1'b1} dmem_state_e;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == MEM_SIZE_B ? 4'b0001 << off :
           size == MEM_SIZE_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    return size == MEM_SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == MEM_SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
  endfunction
endpackage

// File: rtl/chronos_dmem_sram.sv
// chronos_dmem_sram: word-organised SRAM with byte write enables and a combinational read port.
module chronos_dmem_sram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/chronos_dmem_responder.sv
// chronos_dmem_responder: dmem far end; one request at a time, response after LATENCY cycles.
module chronos_dmem_responder
  import chronos_dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req_val,
  output logic        dmem_req_rdy,
  input  logic        dmem_req_rw,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_wdata,
  input  logic [1:0]  dmem_req_size,
  input  logic        dmem_req_unsigned,
  output logic        dmem_resp_val,
  output logic [31:0] dmem_resp_data,
  output logic        dmem_resp_err
);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  dmem_state_e r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        w_acc, w_err, w_resp_nxt, r_pend_err, r_resp_val, r_resp_err;
  logic [1:0]  w_off;
  logic [3:0]  w_we;
  logic [31:0] w_wdata, w_rdata, w_load, r_pend_data, r_resp_data;
  assign dmem_req_rdy = r_state == DMEM_ST_IDLE || (r_state == DMEM_ST_WAIT && r_cnt == 3'd0);
  assign w_acc = dmem_req_val && dmem_req_rdy;
  assign w_off = dmem_req_addr[1:0];
  assign w_err = dmem_req_size == 2'd3 ||
                 (dmem_req_size == MEM_SIZE_H && w_off[0]) ||
                 (dmem_req_size == MEM_SIZE_W && w_off != 2'd0) ||
                 |dmem_req_addr[31:ADDR_WIDTH+2];
  assign w_we = {4{w_acc && dmem_req_rw == MEM_RW_STORE && !w_err}} & lane_mask(dmem_req_size, w_off);
  assign w_wdata = dmem_req_size == MEM_SIZE_B ? {4{dmem_req_wdata[7:0]}} :
                   dmem_req_size == MEM_SIZE_H ? {2{dmem_req_wdata[15:0]}} : dmem_req_wdata;
  assign w_load = (dmem_req_rw == MEM_RW_STORE || w_err) ? 32'd0 :
                  load_extend(w_rdata, dmem_req_size, w_off, dmem_req_unsigned);
  chronos_dmem_sram #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (dmem_req_addr[ADDR_WIDTH+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  always_comb begin
    w_state_nxt = w_acc ? DMEM_ST_WAIT :
                  (r_state == DMEM_ST_WAIT && r_cnt == 3'd0) ? DMEM_ST_IDLE : r_state;
    w_cnt_nxt   = w_acc ? CNT_INIT : r_cnt != 3'd0 ? r_cnt - 3'd1 : r_cnt;
    w_resp_nxt  = w_state_nxt == DMEM_ST_WAIT && w_cnt_nxt == 3'd0;
  end
  // With LATENCY=1 the response follows the accept edge directly, bypassing the pending registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DMEM_ST_IDLE;
      r_cnt       <= 3'd0;
      r_pend_data <= 32'd0;
      r_pend_err  <= 1'b0;
      r_resp_val  <= 1'b0;
      r_resp_data <= 32'd0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_resp_val <= w_resp_nxt;
      r_resp_err <= w_resp_nxt && (w_acc ? w_err : r_pend_err);
      if (w_acc) begin
        r_pend_data <= w_load;
        r_pend_err  <= w_err;
      end
      if (w_resp_nxt) r_resp_data <= w_acc ? w_load : r_pend_data;
    end
  end
  assign dmem_resp_val  = r_resp_val;
  assign dmem_resp_data = r_resp_data;
  assign dmem_resp_err  = r_resp_err;
endmodule
